// File: rtl/axi_read_slave_if_if.sv
// AXI read-address / read-data channel bundle between an interconnect
// slave port (master modport) and the read responder (slave modport).
interface axi_read_slave_if_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_read_slave_if.sv
// AXI read responder: accepts one AR burst at a time, reads each word from a
// 1-cycle-latency synchronous SRAM and returns it as an R beat that is held
// stable under RREADY backpressure.
// Optional address range check: define AXI_RS_RANGE_CHECK_EN to return DECERR
// (and suppress the SRAM strobe) for beats outside MEM_BASE..MEM_WORDS words.
module axi_read_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 14
`ifdef AXI_RS_RANGE_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0] MEM_BASE  = {ADDR_W{1'b0}},
    parameter int unsigned       MEM_WORDS = 16384
`endif
) (
    input  logic                ACLK,
    input  logic                ARESET,
    axi_read_slave_if_if.slave  axi,
    output logic                mem_cs,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic                fixed_q;
    logic [LEN_W-1:0]    beat_q;
    logic                first_q;   // first RESP cycle: data comes straight from SRAM
    logic                oob_q;     // current beat is outside the SRAM window
    logic [DATA_W-1:0]   hold_q;
    logic                arready_q;
    logic                rvalid_q;
    logic                rlast_q;
    logic [1:0]          rresp_q;
    logic [ID_W-1:0]     rid_q;
    logic                mem_cs_q;
    logic [MEM_AW-1:0]   mem_addr_q;

    logic [ADDR_W-1:0]   addr_d;    // address of the beat about to enter MEM
    logic                oob_d;
    logic [MEM_AW-1:0]   word_d;
    logic [DATA_W-1:0]   rdata_s;

    // Address of the next beat: request address on accept, then step per burst type.
    always_comb begin
        addr_d = addr_q;
        if (state_q == IDLE) begin
            addr_d = axi.ARADDR;
        end else if (fixed_q) begin
            addr_d = addr_q;
        end else begin
            addr_d = addr_q + {{(ADDR_W-3){1'b0}}, 3'd4};
        end
    end

`ifdef AXI_RS_RANGE_CHECK_EN
    logic [ADDR_W-1:0] off_d;

    // Translate the beat address into an SRAM word offset and flag out-of-window beats.
    always_comb begin
        off_d = (addr_d - MEM_BASE) >> 2;
        if ((addr_d < MEM_BASE) || (off_d >= ADDR_W'(MEM_WORDS))) begin
            oob_d  = 1'b1;
            word_d = {MEM_AW{1'b0}};
        end else begin
            oob_d  = 1'b0;
            word_d = off_d[MEM_AW-1:0];
        end
    end
`else
    // Without the range check every beat maps straight onto the SRAM word address.
    always_comb begin
        oob_d  = 1'b0;
        word_d = addr_d[MEM_AW+1:2];
    end
`endif

    // Beat data: live SRAM output in the first RESP cycle, hold register afterwards, zero when idle.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        if (!rvalid_q) begin
            rdata_s = {DATA_W{1'b0}};
        end else if (first_q) begin
            if (oob_q) begin
                rdata_s = {DATA_W{1'b0}};
            end else begin
                rdata_s = mem_rdata;
            end
        end else begin
            rdata_s = hold_q;
        end
    end

    // Burst controller: accept AR, alternate MEM/RESP per beat, all outputs registered.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            id_q       <= {ID_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            len_q      <= {LEN_W{1'b0}};
            fixed_q    <= 1'b0;
            beat_q     <= {LEN_W{1'b0}};
            first_q    <= 1'b0;
            oob_q      <= 1'b0;
            hold_q     <= {DATA_W{1'b0}};
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
            rid_q      <= {ID_W{1'b0}};
            mem_cs_q   <= 1'b0;
            mem_addr_q <= {MEM_AW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (axi.ARVALID && arready_q) begin
                        id_q       <= axi.ARID;
                        len_q      <= axi.ARLEN;
                        fixed_q    <= (axi.ARBURST == 2'b00);
                        beat_q     <= {LEN_W{1'b0}};
                        addr_q     <= addr_d;
                        oob_q      <= oob_d;
                        mem_cs_q   <= ~oob_d;
                        mem_addr_q <= word_d;
                        arready_q  <= 1'b0;
                        state_q    <= MEM;
                    end
                end
                MEM: begin
                    mem_cs_q <= 1'b0;
                    rvalid_q <= 1'b1;
                    rid_q    <= id_q;
                    rlast_q  <= (beat_q == len_q);
                    rresp_q  <= oob_q ? 2'b11 : 2'b00;
                    first_q  <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    first_q <= 1'b0;
                    if (first_q) begin
                        hold_q <= rdata_s;
                    end
                    if (axi.RREADY) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        rresp_q  <= 2'b00;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            beat_q     <= beat_q + {{(LEN_W-1){1'b0}}, 1'b1};
                            addr_q     <= addr_d;
                            oob_q      <= oob_d;
                            mem_cs_q   <= ~oob_d;
                            mem_addr_q <= word_d;
                            state_q    <= MEM;
                        end
                    end
                end
                default: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    rlast_q   <= 1'b0;
                    mem_cs_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign axi.ARREADY = arready_q;
    assign axi.RVALID  = rvalid_q;
    assign axi.RLAST   = rlast_q;
    assign axi.RRESP   = rresp_q;
    assign axi.RID     = rid_q;
    assign axi.RDATA   = rdata_s;
    assign mem_cs      = mem_cs_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_axi_read_slave_if.sv
// Directed plus randomized bench for axi_read_slave_if with an SRAM model and
// a beat-list reference model derived from the AXI burst rules.
module tb_axi_read_slave_if;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 32;
    localparam int MEM_AW = 14;
`ifdef AXI_RS_RANGE_CHECK_EN
    localparam logic [31:0] MB = 32'h0;
    localparam int unsigned MW = 16;
`endif

    logic              ACLK;
    logic              ARESET;
    logic              mem_cs;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       sram [0:16383];

    int n_checks = 0;
    int n_fail   = 0;

    axi_read_slave_if_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    axi_read_slave_if #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)
`ifdef AXI_RS_RANGE_CHECK_EN
        , .MEM_BASE(MB), .MEM_WORDS(MW)
`endif
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .axi(bus.slave),
        .mem_cs(mem_cs),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Synchronous SRAM model, one cycle read latency.
    always @(posedge ACLK) begin
        if (mem_cs) mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte address of beat i.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input logic [1:0] b);
        logic [31:0] step;
        step = 32'(4 * i);
        return (b == 2'b00) ? a : a + step;
    endfunction

    function automatic bit is_oob(input logic [31:0] a);
`ifdef AXI_RS_RANGE_CHECK_EN
        return (a < MB) || (((a - MB) >> 2) >= MW);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
`ifdef AXI_RS_RANGE_CHECK_EN
        logic [31:0] o;
        o = (a - MB) >> 2;
        return int'(o[13:0]);
`else
        return int'(a[15:2]);
`endif
    endfunction

    // One full AR burst: present request, then walk MEM/RESP beats against the model.
    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int stall_beat, input int stall_cyc,
                           input bit keep_valid);
        int waited;
        int nst;
        logic [31:0] a;
        bit oob;
        logic [31:0] exp_data;
        bus.ARID    = id;
        bus.ARADDR  = addr;
        bus.ARLEN   = len;
        bus.ARSIZE  = 3'd2;
        bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        waited = 0;
        while (bus.ARREADY !== 1'b1 && waited < 40) begin
            @(posedge ACLK); #1;
            waited++;
        end
        chk("ar_accept_timeout", 64'(waited >= 40), 64'd0);
        if (waited >= 40) begin
            bus.ARVALID = 1'b0;
            return;
        end
        @(posedge ACLK); #1;
        if (!keep_valid) bus.ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a   = beat_addr(addr, i, burst);
            oob = is_oob(a);
            chk("mem_cs_in_mem", 64'(mem_cs), 64'(!oob));
            if (!oob) chk("mem_addr", 64'(mem_addr), 64'(word_of(a)));
            chk("rvalid_in_mem", 64'(bus.RVALID), 64'd0);
            chk("rdata_zero_idle", 64'(bus.RDATA), 64'd0);
            if (keep_valid) chk("busy_arready", 64'(bus.ARREADY), 64'd0);
            @(posedge ACLK); #1;
            exp_data = oob ? 32'h0 : sram[word_of(a)];
            nst = (i == stall_beat) ? stall_cyc : 0;
            for (int s = 0; s <= nst; s++) begin
                chk("rvalid", 64'(bus.RVALID), 64'd1);
                chk("rid", 64'(bus.RID), 64'(id));
                chk("rdata", 64'(bus.RDATA), 64'(exp_data));
                chk("rlast", 64'(bus.RLAST), 64'(i == int'(len)));
                chk("rresp", 64'(bus.RRESP), oob ? 64'd3 : 64'd0);
                chk("mem_cs_in_resp", 64'(mem_cs), 64'd0);
                if (keep_valid) chk("busy_arready_resp", 64'(bus.ARREADY), 64'd0);
                bus.RREADY = (s == nst) ? 1'b1 : 1'b0;
                @(posedge ACLK); #1;
            end
            bus.RREADY = 1'b0;
        end
        chk("arready_after_burst", 64'(bus.ARREADY), 64'd1);
        chk("rvalid_after_burst", 64'(bus.RVALID), 64'd0);
    endtask

    initial begin
        logic [3:0]  rlen;
        logic [31:0] raddr;
        int          waited;
        for (int k = 0; k < 16384; k++) sram[k] = $urandom;
        sram[4] = 32'hDEADBEEF;
        bus.ARID = 8'h00; bus.ARADDR = 32'h0; bus.ARLEN = 4'h0; bus.ARSIZE = 3'd2;
        bus.ARBURST = 2'b01; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        mem_rdata = 32'h0;

        // Reset state
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_arready", 64'(bus.ARREADY), 64'd0);
        chk("rst_rvalid", 64'(bus.RVALID), 64'd0);
        chk("rst_rlast", 64'(bus.RLAST), 64'd0);
        chk("rst_rid", 64'(bus.RID), 64'd0);
        chk("rst_rdata", 64'(bus.RDATA), 64'd0);
        chk("rst_rresp", 64'(bus.RRESP), 64'd0);
        chk("rst_mem_cs", 64'(mem_cs), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        ARESET = 1'b0;
        chk("rst_exit_arready", 64'(bus.ARREADY), 64'd0);
        @(posedge ACLK); #1;

        // Single read, INCR and FIXED bursts
        do_read(8'h15, 32'h0000_0010, 4'd0, 2'b01, -1, 0, 1'b0);
        do_read(8'h21, 32'h0000_0100, 4'd3, 2'b01, -1, 0, 1'b0);
        do_read(8'h22, 32'h0000_0100, 4'd3, 2'b00, -1, 0, 1'b0);
        // Backpressure on beat 2 of a 3-beat burst
        do_read(8'h33, 32'h0000_0200, 4'd2, 2'b01, 1, 5, 1'b0);
        // Busy rejection: request stays valid during burst, then is accepted
        do_read(8'h44, 32'h0000_0300, 4'd3, 2'b10, -1, 0, 1'b1);
        do_read(8'h44, 32'h0000_0300, 4'd3, 2'b10, -1, 0, 1'b0);
        // Address wrap and ignored low address bits
        do_read(8'h55, 32'hFFFF_FFFB, 4'd3, 2'b01, 2, 1, 1'b0);
        // Range window edge (out of range beats only with the range check)
        do_read(8'h66, 32'h0000_0038, 4'd3, 2'b01, -1, 0, 1'b0);
        // 16-beat burst
        do_read(8'h77, 32'h0000_1000, 4'd15, 2'b01, 7, 2, 1'b0);

        // Reset during beat 1 of an 8-beat burst
        bus.ARID = 8'h88; bus.ARADDR = 32'h400; bus.ARLEN = 4'd7; bus.ARBURST = 2'b01;
        bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        waited = 0;
        while (bus.ARREADY !== 1'b1 && waited < 40) begin
            @(posedge ACLK); #1;
            waited++;
        end
        chk("rst_burst_accept", 64'(bus.ARREADY), 64'd1);
        @(posedge ACLK); #1;
        bus.ARVALID = 1'b0;
        @(posedge ACLK); #1;
        chk("rst_burst_rvalid_pre", 64'(bus.RVALID), 64'd1);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        chk("rst_mid_rvalid", 64'(bus.RVALID), 64'd0);
        chk("rst_mid_mem_cs", 64'(mem_cs), 64'd0);
        chk("rst_mid_arready", 64'(bus.ARREADY), 64'd0);
        chk("rst_mid_rdata", 64'(bus.RDATA), 64'd0);
        ARESET = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge ACLK); #1;
            chk("post_rst_mem_cs", 64'(mem_cs), 64'd0);
            chk("post_rst_rvalid", 64'(bus.RVALID), 64'd0);
        end
        chk("post_rst_arready", 64'(bus.ARREADY), 64'd1);

        // Randomized bursts
        for (int t = 0; t < 20; t++) begin
            rlen  = 4'($urandom_range(0, 15));
            raddr = $urandom;
            if (t < 10) raddr = {26'h0, 6'($urandom)};
            do_read(8'($urandom), raddr, rlen, 2'($urandom_range(0, 3)),
                    $urandom_range(0, int'(rlen)), $urandom_range(0, 3), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_slave_if.md
Name: axi_read_slave_if

Overview:
- AXI read-channel responder on the slave side of the interconnect; the far end of the AR/R path that the master-side arbitration drives.
- Accepts one AR request at a time, walks the burst and issues single-word reads to a 1-cycle-latency synchronous SRAM.
- Returns each word as an R beat with RID, RRESP and RLAST, and holds it stable under RREADY backpressure.
- Sits between an interconnect slave port and an SRAM/ROM wrapper.

Parameters:
- ID_W, 8, width of ARID/RID (slave-side ID, master ID extended by the interconnect).
- ADDR_W, 32, byte address width.
- LEN_W, 4, ARLEN width; a burst has ARLEN+1 beats, 1..16.
- DATA_W, 32, RDATA / mem_rdata width; one beat is one word.
- MEM_AW, 14, SRAM word-address width.
- MEM_BASE, 32'h0, byte base address of the SRAM; used only with the optional feature.
- MEM_WORDS, 16384, number of valid SRAM words; used only with the optional feature.

Ports:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESET  in  1  synchronous active-high reset.
- ARID  in  ID_W  request ID.
- ARADDR  in  ADDR_W  start byte address; bits [1:0] ignored.
- ARLEN  in  LEN_W  beats minus 1.
- ARSIZE  in  3  captured, ignored; always word transfers.
- ARBURST  in  2  2'b00 FIXED; any other value is treated as INCR.
- ARVALID  in  1  request valid.
- ARREADY  out  1  request accept.
- RID  out  ID_W  latched ARID.
- RDATA  out  DATA_W  beat data.
- RRESP  out  2  2'b00 OKAY, or 2'b11 DECERR with the optional feature.
- RLAST  out  1  final beat.
- RVALID  out  1  beat valid.
- RREADY  in  1  master accept.
- mem_cs  out  1  SRAM read strobe.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_cs.

Behaviour:
- FSM states: IDLE, MEM, RESP. ARESET high forces IDLE on the next edge.
- Outputs while ARESET is high and on exit from reset: ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, mem_cs=0, mem_addr=0.
- IDLE:
  - ARREADY=1 (0 while ARESET is high).
  - On ARVALID&ARREADY: latch ARID, ARADDR, ARLEN, ARBURST; set beat_cnt=0; go to MEM.
- MEM (one cycle):
  - mem_cs=1, mem_addr=cur_addr[MEM_AW+1:2]; ARREADY=0; next state RESP.
- RESP:
  - RVALID=1; RID=latched ID; RLAST=(beat_cnt==len_reg).
  - RDATA comes from mem_rdata in the first RESP cycle, which also loads a hold register. Later RESP cycles drive RDATA from the hold register, so RDATA/RRESP/RLAST/RID stay constant until RREADY.
  - On RREADY with RLAST: go to IDLE.
  - On RREADY without RLAST: beat_cnt+1; cur_addr+4 for INCR, unchanged for FIXED; go to MEM.
- Latency: AR handshake at edge N gives mem_cs in cycle N+1 and RVALID in cycle N+2. Each later beat takes 2 cycles minimum (MEM+RESP).
- RDATA is 0 whenever RVALID=0.
- A new AR is accepted no earlier than the cycle after the last RREADY handshake; no outstanding transactions and no interleaving.
- ARVALID while busy is not accepted (ARREADY=0); the master holds its request.
- cur_addr increments modulo 2^ADDR_W; no 4KB-boundary check.
- ARLEN=0 gives a single beat with RLAST=1. ARLEN=15 gives 16 beats.
- ARESET asserted mid-burst: the burst is discarded, RVALID drops after the edge, and no further mem_cs is issued.

Optional Feature:
- Macro AXI_RS_RANGE_CHECK_EN.
- Defined:
  - Each beat computes off=(cur_addr-MEM_BASE)>>2.
  - If off>=MEM_WORDS or cur_addr<MEM_BASE: the MEM cycle runs with mem_cs=0, and the beat returns RRESP=2'b11 with RDATA=0. Timing and beat count are unchanged.
  - In-range beats return RRESP=2'b00 with mem_addr=off[MEM_AW-1:0].
- Undefined: RRESP is always 2'b00; mem_addr=cur_addr[MEM_AW+1:2]; MEM_BASE and MEM_WORDS are unused.

Test Plan:
- Single read: ARADDR=32'h10, ARLEN=0, ARID=8'h15, SRAM[4]=32'hDEADBEEF, RREADY=1 -> mem_cs with mem_addr=4 in cycle N+1; RVALID, RLAST=1, RID=8'h15, RDATA=32'hDEADBEEF in N+2; ARREADY=1 in N+3.
- INCR burst: ARADDR=32'h100, ARLEN=3 -> 4 beats from mem_addr 64,65,66,67, RLAST only on the 4th; FIXED burst with the same inputs -> 4 beats from mem_addr 64.
- Backpressure: RREADY low for 5 cycles on beat 2 of ARLEN=2 -> RDATA/RID/RLAST stable throughout, no extra mem_cs, burst completes with 3 beats.
- Busy rejection plus reset: a second ARVALID during a burst sees ARREADY=0 until the burst ends. ARESET during beat 1 of ARLEN=7 -> RVALID=0 and mem_cs=0 after the edge, ARREADY=1 after release.
- With AXI_RS_RANGE_CHECK_EN, MEM_BASE=0, MEM_WORDS=16: ARADDR=32'h38, ARLEN=3 -> beats 1-2 OKAY from words 14,15; beats 3-4 RRESP=2'b11, RDATA=0, mem_cs=0.
